// File: rtl/iram_loadable.sv
// rtl/iram_loadable.sv - loadable instruction memory: word-wide fetch port plus byte-serial program-load port
// Memory is zero-swept after reset and before every load, so unloaded words always read as zero.
module iram_loadable #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 512,
    parameter int REG_OUT = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [ADDR_W-1:0]        ADDR,
    output logic [DATA_W-1:0]        Q,
    output logic                     READY,
    input  logic                     LD_START,
    input  logic                     LD_VALID,
    input  logic [7:0]               LD_BYTE,
    input  logic                     LD_LAST,
    output logic                     LD_READY,
    output logic                     LD_DONE,
    output logic                     LD_OVF,
    output logic [$clog2(DEPTH):0]   LD_WORDS
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0]     DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]     LAST_P  = PW'(DEPTH - 1);
    localparam logic [CW-1:0]     CNT_TOP = CW'(BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       words_q, words_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   asm_q, asm_d;
    logic                then_load_q, then_load_d;
    logic                ovf_q, ovf_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W+7:0]   cat;
    logic [DATA_W-1:0]   shifted;
    logic                word_full;
    int                  pad_sh;

    assign cat       = {asm_q, LD_BYTE};
    assign shifted   = cat[DATA_W-1:0];
    assign word_full = (cnt_q == CNT_TOP);
    // Left-align a partial word so the missing low bytes become zero padding.
    assign pad_sh    = (BYTES - 1 - int'(cnt_q)) * 8;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        then_load_d = then_load_q;
        ovf_d       = ovf_q;
        we          = 1'b0;
        waddr       = ptr_q[AW-1:0];
        wdata       = '0;
        case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_P) begin
                    ptr_d       = '0;
                    then_load_d = 1'b0;
                    state_d     = then_load_q ? S_LOAD : S_IDLE;
                end
            end
            S_IDLE: begin
                if (LD_START) begin
                    ptr_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    words_d     = '0;
                    then_load_d = 1'b1;
                    state_d     = S_CLEAR;
                end
            end
            S_LOAD: begin
                if (LD_VALID) begin
                    asm_d = shifted;
                    cnt_d = word_full ? '0 : cnt_q + 1'b1;
                    if (ptr_q == DEPTH_P) begin
                        ovf_d = 1'b1;
                    end else if (word_full || LD_LAST) begin
                        we      = 1'b1;
                        wdata   = shifted << pad_sh;
                        ptr_d   = ptr_q + 1'b1;
                        words_d = words_q + 1'b1;
                    end
                    if (LD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_CLEAR;
            ptr_q       <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            asm_q       <= '0;
            then_load_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            then_load_q <= then_load_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we && !RESET) mem[waddr] <= wdata;
    end

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] raw_rd;

    assign idx    = ADDR >> BSH;
    assign raw_rd = ({1'b0, idx} < DEPTH_A) ? mem[idx[AW-1:0]] : '0;

    assign READY    = (state_q == S_IDLE);
    assign LD_READY = (state_q == S_LOAD);
    assign LD_DONE  = (state_q == S_DONE);
    assign LD_OVF   = ovf_q;
    assign LD_WORDS = words_q;

    generate
        if (REG_OUT != 0) begin : g_reg_q
            logic [DATA_W-1:0] q_q;
            always_ff @(posedge CLK) begin
                if (RESET) q_q <= '0;
                else       q_q <= raw_rd;
            end
            assign Q = READY ? q_q : '0;
        end else begin : g_comb_q
            assign Q = READY ? raw_rd : '0;
        end
    endgenerate
endmodule

// File: tb/tb_iram_loadable.sv
// tb/tb_iram_loadable.sv - self-checking bench: DEPTH=512 combinational and DEPTH=4 registered instances
module tb_iram_loadable;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, ld_start, ld_valid, ld_last;
    logic [1:0][7:0]  ld_byte;
    logic [1:0][9:0]  addr;

    logic [15:0] q_a, q_b;
    logic        ready_a, ready_b, ldr_a, ldr_b, done_a, done_b, ovf_a, ovf_b;
    logic [9:0]  words_a;
    logic [2:0]  words_b;

    iram_loadable #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .REG_OUT(0)) u_a (
        .CLK(clk), .RESET(rst[0]), .ADDR(addr[0]), .Q(q_a), .READY(ready_a),
        .LD_START(ld_start[0]), .LD_VALID(ld_valid[0]), .LD_BYTE(ld_byte[0]),
        .LD_LAST(ld_last[0]), .LD_READY(ldr_a), .LD_DONE(done_a),
        .LD_OVF(ovf_a), .LD_WORDS(words_a)
    );

    iram_loadable #(.DATA_W(16), .ADDR_W(10), .DEPTH(4), .REG_OUT(1)) u_b (
        .CLK(clk), .RESET(rst[1]), .ADDR(addr[1]), .Q(q_b), .READY(ready_b),
        .LD_START(ld_start[1]), .LD_VALID(ld_valid[1]), .LD_BYTE(ld_byte[1]),
        .LD_LAST(ld_last[1]), .LD_READY(ldr_b), .LD_DONE(done_b),
        .LD_OVF(ovf_b), .LD_WORDS(words_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: expected memory image and load status per instance.
    logic [15:0] exp_mem [2][512];
    int          depth [2] = '{512, 4};
    int          exp_words [2];
    logic        exp_ovf [2];
    logic [7:0]  prog [$];

    function automatic logic [15:0] get_q(int s);     return (s != 0) ? q_b : q_a;         endfunction
    function automatic logic        get_ready(int s); return (s != 0) ? ready_b : ready_a; endfunction
    function automatic logic        get_ldr(int s);   return (s != 0) ? ldr_b : ldr_a;     endfunction
    function automatic logic        get_done(int s);  return (s != 0) ? done_b : done_a;   endfunction
    function automatic logic        get_ovf(int s);   return (s != 0) ? ovf_b : ovf_a;     endfunction
    function automatic int          get_words(int s); return (s != 0) ? int'(words_b) : int'(words_a); endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_load(input int s);
        int n;
        n = prog.size();
        for (int w = 0; w < depth[s]; w++) exp_mem[s][w] = 16'h0000;
        for (int b = 0; b < n; b++) begin
            if (b / 2 < depth[s]) begin
                if (b % 2 == 0) exp_mem[s][b/2][15:8] = prog[b];
                else            exp_mem[s][b/2][7:0]  = prog[b];
            end
        end
        exp_words[s] = ((n + 1) / 2 < depth[s]) ? (n + 1) / 2 : depth[s];
        exp_ovf[s]   = (n > 2 * depth[s]);
    endtask

    // mode 0: no stalls, 1: LD_VALID every other cycle, 2: random stalls
    task automatic do_load(input int s, input int mode);
        int i, t, dones;
        logic xfer;
        i = 0; t = 0; dones = 0;
        ld_start[s] = 1'b1;
        step();
        ld_start[s] = 1'b0;
        while (i < prog.size() && t < 5000) begin
            case (mode)
                0:       ld_valid[s] = 1'b1;
                1:       ld_valid[s] = (t % 2 == 0);
                default: ld_valid[s] = 1'($urandom_range(0, 1));
            endcase
            ld_byte[s] = prog[i];
            ld_last[s] = (i == prog.size() - 1);
            xfer = ld_valid[s] && get_ldr(s);
            step();
            t++;
            dones += int'(get_done(s));
            if (xfer) i++;
        end
        ld_valid[s] = 1'b0;
        ld_last[s]  = 1'b0;
        while (!get_ready(s) && t < 5000) begin
            step();
            t++;
            dones += int'(get_done(s));
        end
        chk($sformatf("load%0d_finished", s), 32'(t < 5000), 32'd1);
        chk($sformatf("load%0d_done_pulses", s), 32'(dones), 32'd1);
        chk($sformatf("load%0d_words", s), 32'(get_words(s)), 32'(exp_words[s]));
        chk($sformatf("load%0d_ovf", s), 32'(get_ovf(s)), 32'(exp_ovf[s]));
    endtask

    task automatic check_mem(input int s);
        logic [15:0] e;
        if (s == 0) begin
            for (int i = 0; i < 512; i++) begin
                addr[0] = 10'(i * 2 + int'($urandom_range(0, 1)));
                #1;
                chk($sformatf("A_word%0d", i), 32'(q_a), 32'(exp_mem[0][i]));
            end
        end else begin
            for (int i = 0; i <= 4; i++) begin
                addr[1] = 10'(i * 2 + int'($urandom_range(0, 1)));
                step();
                e = (i < 4) ? exp_mem[1][i] : 16'h0000;
                chk($sformatf("B_word%0d", i), 32'(q_b), 32'(e));
            end
        end
    endtask

    initial begin
        int c, dones, n;
        rst = 2'b11; ld_start = '0; ld_valid = '0; ld_last = '0; ld_byte = '0; addr = '0;
        step();
        rst = 2'b00;

        chk("rst_ready_a", 32'(ready_a), 32'd0);
        chk("rst_ldready_a", 32'(ldr_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_ovf_a", 32'(ovf_a), 32'd0);
        chk("rst_words_a", 32'(words_a), 32'd0);
        chk("rst_q_a", 32'(q_a), 32'd0);
        chk("rst_q_b", 32'(q_b), 32'd0);

        c = 0;
        while (!ready_a && c < 600) begin step(); c++; end
        chk("A_clear_cycles", 32'(c), 32'd512);
        chk("idle_ldready_a", 32'(ldr_a), 32'd0);

        prog = {};
        model_load(0);
        foreach (addr[k]) addr[k] = '0;
        addr[0] = 10'd1022; #1;
        chk("A_addr1022_after_reset", 32'(q_a), 32'd0);
        check_mem(0);

        prog = '{8'hF0, 8'h08, 8'hF0, 8'h10, 8'h00, 8'h01};
        model_load(0);
        do_load(0, 0);
        chk("basic_words", 32'(words_a), 32'd3);
        addr[0] = 10'd1; #1; chk("basic_addr1", 32'(q_a), 32'h0000F008);
        addr[0] = 10'd4; #1; chk("basic_addr4", 32'(q_a), 32'h00000001);
        addr[0] = 10'd6; #1; chk("basic_addr6", 32'(q_a), 32'h00000000);
        check_mem(0);

        do_load(0, 1);
        check_mem(0);

        prog = '{8'h12, 8'h34, 8'h56};
        model_load(0);
        do_load(0, 2);
        chk("odd_words", 32'(words_a), 32'd2);
        addr[0] = 10'd2; #1; chk("odd_word1", 32'(q_a), 32'h00005600);
        check_mem(0);

        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 60));
            prog = {};
            for (int b = 0; b < n; b++) prog.push_back(8'($urandom));
            model_load(0);
            do_load(0, int'($urandom_range(0, 2)));
            check_mem(0);
        end

        // Reset in the middle of a load: no LD_DONE, full sweep, memory zeroed.
        ld_start[0] = 1'b1; step(); ld_start[0] = 1'b0;
        c = 0;
        while (!ldr_a && c < 600) begin step(); c++; end
        chk("abort_reached_load", 32'(ldr_a), 32'd1);
        for (int b = 0; b < 3; b++) begin
            ld_valid[0] = 1'b1; ld_byte[0] = 8'(8'hA0 + b); ld_last[0] = 1'b0;
            step();
        end
        ld_valid[0] = 1'b0;
        rst[0] = 1'b1; step(); rst[0] = 1'b0;
        c = 0; dones = 0;
        while (!ready_a && c < 600) begin step(); c++; dones += int'(done_a); end
        chk("abort_clear_cycles", 32'(c), 32'd512);
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_words", 32'(words_a), 32'd0);
        chk("abort_ovf", 32'(ovf_a), 32'd0);
        prog = {};
        model_load(0);
        check_mem(0);

        // DEPTH=4 registered instance: overflow, re-load, fetch latency.
        chk("B_ready", 32'(ready_b), 32'd1);
        prog = {};
        for (int b = 1; b <= 10; b++) prog.push_back(8'(b));
        model_load(1);
        do_load(1, 0);
        chk("ovf_words", 32'(words_b), 32'd4);
        chk("ovf_flag", 32'(ovf_b), 32'd1);
        check_mem(1);

        addr[1] = 10'd0; step();
        chk("regout_word0", 32'(q_b), 32'h00000102);
        addr[1] = 10'd2; #1;
        chk("regout_hold", 32'(q_b), 32'h00000102);
        step();
        chk("regout_word1", 32'(q_b), 32'h00000304);

        prog = '{8'h77, 8'h88};
        model_load(1);
        do_load(1, 0);
        chk("reload_ovf_cleared", 32'(ovf_b), 32'd0);
        addr[1] = 10'd2; step();
        chk("reload_word1_zero", 32'(q_b), 32'd0);
        check_mem(1);

        n = int'($urandom_range(1, 12));
        prog = {};
        for (int b = 0; b < n; b++) prog.push_back(8'($urandom));
        model_load(1);
        do_load(1, 2);
        check_mem(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
